// File: rtl/vga_timing_gen.sv
// Runtime-programmable video timing generator: x/y counters, sync/DE decode,
// frame-boundary config swap and a configurable output delay line.
module vga_timing_gen #(
   parameter int unsigned CoordWidth = 12,
   parameter int unsigned HActive    = 800,
   parameter int unsigned HFp        = 40,
   parameter int unsigned HSync      = 128,
   parameter int unsigned HBp        = 88,
   parameter int unsigned VActive    = 600,
   parameter int unsigned VFp        = 1,
   parameter int unsigned VSync      = 4,
   parameter int unsigned VBp        = 23,
   parameter bit          HsyncPol   = 1'b1,
   parameter bit          VsyncPol   = 1'b1,
   parameter int unsigned Delay      = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [4*CoordWidth-1:0]   cfg_h,
   input  logic [4*CoordWidth-1:0]   cfg_v,
   output logic [CoordWidth-1:0]     x,
   output logic [CoordWidth-1:0]     y,
   output logic                      de,
   output logic                      hsync,
   output logic                      vsync,
   output logic                      line_start,
   output logic                      frame_start
);

   localparam int unsigned W = CoordWidth;
   typedef logic [W-1:0] coord_t;
   typedef logic [W:0]   sum_t;

   localparam logic [4*W-1:0] DefH = {W'(HBp), W'(HSync), W'(HFp), W'(HActive)};
   localparam logic [4*W-1:0] DefV = {W'(VBp), W'(VSync), W'(VFp), W'(VActive)};

   logic [4*W-1:0] act_h, act_v, pend_h, pend_v;
   logic           pend_valid;

   coord_t ha, hf, hs, hb, va, vf, vs, vb;
   sum_t   h_fp_end, h_sync_end, htotal, v_fp_end, v_sync_end, vtotal;
   logic   x_last, y_last, run;
   logic   de_i, hs_i, vs_i, ls_i, fs_i;
   logic [4:0] cur, dly;

   assign ha = act_h[0*W +: W];
   assign hf = act_h[1*W +: W];
   assign hs = act_h[2*W +: W];
   assign hb = act_h[3*W +: W];
   assign va = act_v[0*W +: W];
   assign vf = act_v[1*W +: W];
   assign vs = act_v[2*W +: W];
   assign vb = act_v[3*W +: W];

   // Totals are one bit wider so a full 2^W-pixel line is representable.
   assign h_fp_end   = {1'b0, ha} + {1'b0, hf};
   assign h_sync_end = h_fp_end + {1'b0, hs};
   assign htotal     = h_sync_end + {1'b0, hb};
   assign v_fp_end   = {1'b0, va} + {1'b0, vf};
   assign v_sync_end = v_fp_end + {1'b0, vs};
   assign vtotal     = v_sync_end + {1'b0, vb};

   assign x_last = ({1'b0, x} == htotal - sum_t'(1));
   assign y_last = ({1'b0, y} == vtotal - sum_t'(1));

   assign run  = enable && !reset;
   assign de_i = run && (x < ha) && (y < va);
   assign hs_i = run && ({1'b0, x} >= h_fp_end) && ({1'b0, x} < h_sync_end);
   assign vs_i = run && ({1'b0, y} >= v_fp_end) && ({1'b0, y} < v_sync_end);
   assign ls_i = run && (x == '0);
   assign fs_i = ls_i && (y == '0);
   assign cur  = {fs_i, ls_i, vs_i, hs_i, de_i};

   assign cfg_ready = !pend_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         x          <= '0;
         y          <= '0;
         act_h      <= DefH;
         act_v      <= DefV;
         pend_h     <= '0;
         pend_v     <= '0;
         pend_valid <= 1'b0;
      end else begin
         if (!enable) begin
            x <= '0;
            y <= '0;
         end else if (x_last) begin
            x <= '0;
            y <= y_last ? '0 : y + coord_t'(1);
         end else begin
            x <= x + coord_t'(1);
         end

         // Pending timing lands together with x,y -> 0,0 so a frame never mixes timings.
         if (pend_valid && (!enable || (x_last && y_last))) begin
            act_h      <= pend_h;
            act_v      <= pend_v;
            pend_valid <= 1'b0;
         end else if (cfg_valid && !pend_valid) begin
            pend_h     <= cfg_h;
            pend_v     <= cfg_v;
            pend_valid <= 1'b1;
         end
      end
   end

   generate
      if (Delay == 0) begin : g_nodly
         assign dly = cur;
      end else begin : g_dly
         logic [4:0] pipe [Delay];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int unsigned i = 0; i < Delay; i++) pipe[i] <= '0;
            end else begin
               pipe[0] <= cur;
               for (int unsigned i = 1; i < Delay; i++) pipe[i] <= pipe[i-1];
            end
         end
         assign dly = pipe[Delay-1];
      end
   endgenerate

   assign de          = dly[0];
   assign hsync       = dly[1] ^ !HsyncPol;
   assign vsync       = dly[2] ^ !VsyncPol;
   assign line_start  = dly[3];
   assign frame_start = dly[4];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, config swaps, enable/reset
// behaviour, plus an active-low, zero-delay instance.
module tb_vga_timing_gen;

   logic        clk, reset, enable, eb, cfg_valid, cfg_valid_b;
   logic [47:0] cfg_h, cfg_v;
   logic        cfg_ready, de, hsync, vsync, line_start, frame_start;
   logic [11:0] x, y;
   logic        cfg_ready_b, de_b, hsync_b, vsync_b, line_start_b, frame_start_b;
   logic [11:0] x_b, y_b;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [47:0] CfgAH = {12'd1, 12'd2, 12'd1, 12'd4};
   localparam logic [47:0] CfgAV = {12'd1, 12'd1, 12'd1, 12'd3};
   localparam logic [47:0] CfgBH = {12'd1, 12'd3, 12'd2, 12'd6};
   localparam logic [47:0] CfgBV = {12'd1, 12'd2, 12'd1, 12'd2};
   localparam logic [47:0] CfgCH = {12'd1, 12'd1, 12'd1, 12'd2};
   localparam logic [47:0] CfgCV = {12'd0, 12'd1, 12'd0, 12'd2};

   vga_timing_gen dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_h(cfg_h), .cfg_v(cfg_v),
      .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
      .line_start(line_start), .frame_start(frame_start));

   vga_timing_gen #(.HsyncPol(1'b0), .VsyncPol(1'b0), .Delay(0)) dut_b (
      .clk(clk), .reset(reset), .enable(eb),
      .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b), .cfg_h(cfg_h), .cfg_v(cfg_v),
      .x(x_b), .y(y_b), .de(de_b), .hsync(hsync_b), .vsync(vsync_b),
      .line_start(line_start_b), .frame_start(frame_start_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int xerr, fs_cnt, fs_first, hs_hi, de_cnt, bl_cnt, b_first_low, vs_bad, patt_err;
      int rise[$];
      int fs_q[$];
      int fs_exp[5];
      logic hs_prev;
      logic [7:0] de_row, hs_row;
      logic [5:0] de_col, vs_col;

      xerr = 0; fs_cnt = 0; fs_first = -1; hs_hi = 0; de_cnt = 0;
      bl_cnt = 0; b_first_low = -1; vs_bad = 0; patt_err = 0; hs_prev = 1'b0;
      fs_exp = '{2, 50, 98, 170, 185};
      de_row = 8'b0000_1111; hs_row = 8'b0110_0000;
      de_col = 6'b00_0111;   vs_col = 6'b01_0000;

      reset = 1'b1; enable = 1'b0; eb = 1'b0;
      cfg_valid = 1'b0; cfg_valid_b = 1'b0; cfg_h = '0; cfg_v = '0;
      repeat (3) tick();

      check("rst_x", 32'(x), 0);
      check("rst_y", 32'(y), 0);
      check("rst_ready", 32'(cfg_ready), 1);
      check("rst_de", 32'(de), 0);
      check("rst_hsync", 32'(hsync), 0);
      check("rst_vsync", 32'(vsync), 0);
      check("rst_strobes", 32'({line_start, frame_start}), 0);
      check("rst_b_syncs_idle_high", 32'({hsync_b, vsync_b}), 3);

      // Default timing, enable rises on x=y=0
      reset = 1'b0; enable = 1'b1; eb = 1'b1;
      #1;
      check("b_fs_no_lag", 32'(frame_start_b), 1);
      check("b_de_no_lag", 32'(de_b), 1);
      check("b_hsync_idle", 32'(hsync_b), 1);

      for (int t = 1; t <= 2117; t++) begin
         tick();
         if (x !== 12'(t % 1056) || y !== 12'(t / 1056)) xerr++;
         if (frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = t;
         end
         if (hsync && !hs_prev) rise.push_back(t);
         hs_prev = hsync;
         if (t >= 2 && t <= 1057) begin
            if (hsync) hs_hi++;
            if (de) de_cnt++;
         end
         if (t <= 1056 && !hsync_b) begin
            bl_cnt++;
            if (b_first_low < 0) b_first_low = t;
         end
         if (vsync || !vsync_b) vs_bad++;
         if (t == 799) check("b_de_last_px", 32'(de_b), 1);
         if (t == 800) check("b_de_blank", 32'(de_b), 0);
         if (t == 1058) check("a_line_start", 32'(line_start), 1);
         if (t == 1500) begin
            check("a_ready_idle", 32'(cfg_ready), 1);
            cfg_h = CfgAH; cfg_v = CfgAV; cfg_valid = 1'b1;
         end
         if (t == 1501) begin
            check("a_ready_drop", 32'(cfg_ready), 0);
            cfg_valid = 1'b0;
         end
      end
      check("a_xy_sequence", 32'(xerr), 0);
      check("a_fs_first", 32'(fs_first), 2);
      check("a_fs_count", 32'(fs_cnt), 1);
      check("a_hs_rises", 32'(rise.size()), 2);
      if (rise.size() >= 2) begin
         check("a_hs_first_rise", 32'(rise[0]), 842);
         check("a_hs_period", 32'(rise[1] - rise[0]), 1056);
      end
      check("a_hs_width", 32'(hs_hi), 128);
      check("a_de_width", 32'(de_cnt), 800);
      check("b_hs_low_width", 32'(bl_cnt), 128);
      check("b_hs_first_low", 32'(b_first_low), 840);
      check("vsync_idle_top_lines", 32'(vs_bad), 0);

      // Drop enable at x=5,y=2 with A pending
      check("pre_drop_x", 32'(x), 5);
      check("pre_drop_y", 32'(y), 2);
      enable = 1'b0;
      tick();
      check("drop_x", 32'(x), 0);
      check("drop_y", 32'(y), 0);
      check("drop_ready", 32'(cfg_ready), 1);
      check("drop_de_in_pipe", 32'(de), 1);
      tick();
      tick();
      check("drop_idle_de", 32'(de), 0);
      check("drop_idle_sync", 32'({hsync, vsync, line_start, frame_start}), 0);
      repeat (3) tick();

      // Re-enable on timing A (8x6), then B then C via back-to-back offers
      enable = 1'b1;
      for (int s = 1; s <= 193; s++) begin
         tick();
         if (frame_start) fs_q.push_back(s);
         if (s <= 95 && (x !== 12'(s % 8) || y !== 12'((s / 8) % 6))) xerr++;
         if (s >= 2 && s <= 49) begin
            int c;
            c = s - 2;
            if (de !== (de_row[c % 8] & de_col[c / 8]) || hsync !== hs_row[c % 8] ||
                vsync !== vs_col[c / 8] || line_start !== (c % 8 == 0) ||
                frame_start !== (c == 0)) patt_err++;
         end
         if (s == 60) begin
            check("a_ready_before_b", 32'(cfg_ready), 1);
            cfg_h = CfgBH; cfg_v = CfgBV; cfg_valid = 1'b1;
         end
         if (s == 61) begin
            check("b_cfg_taken", 32'(cfg_ready), 0);
            cfg_h = CfgCH; cfg_v = CfgCV;
         end
         if (s == 95) begin
            check("c_held_off", 32'(cfg_ready), 0);
            check("a_wrap_xy", 32'({x, y}), 32'({12'd7, 12'd5}));
         end
         if (s == 96) begin
            check("b_applied_xy", 32'({x, y}), 0);
            check("ready_after_apply", 32'(cfg_ready), 1);
         end
         if (s == 97) begin
            check("c_cfg_taken", 32'(cfg_ready), 0);
            cfg_valid = 1'b0;
         end
         if (s == 105) check("b_hs_before", 32'(hsync), 0);
         if (s == 106) check("b_hs_start", 32'(hsync), 1);
         if (s == 107) check("b_x_last", 32'({x, y}), 32'({12'd11, 12'd0}));
         if (s == 108) check("b_htotal_wrap", 32'({x, y}), 32'({12'd0, 12'd1}));
         if (s == 133) check("b_vs_before", 32'(vsync), 0);
         if (s == 134) check("b_vs_start", 32'(vsync), 1);
         if (s == 168) check("c_applied_xy", 32'({x, y}), 0);
         if (s == 169) check("ready_after_c", 32'(cfg_ready), 1);
         if (s == 172) check("c_x_last", 32'({x, y}), 32'({12'd4, 12'd0}));
         if (s == 173) check("c_htotal_wrap", 32'({x, y}), 32'({12'd0, 12'd1}));
         if (s == 183) check("c_vtotal_wrap", 32'({x, y}), 0);
         if (s == 190) begin
            check("ready_before_rst_offer", 32'(cfg_ready), 1);
            cfg_h = CfgAH; cfg_v = CfgAV; cfg_valid = 1'b1;
         end
         if (s == 191) begin
            check("rst_offer_taken", 32'(cfg_ready), 0);
            cfg_valid = 1'b0;
         end
      end
      check("a_small_xy_sequence", 32'(xerr), 0);
      check("a_small_frame_pattern", 32'(patt_err), 0);
      check("fs_count_abc", 32'(fs_q.size()), 5);
      for (int i = 0; i < 5 && i < fs_q.size(); i++) check("fs_position", 32'(fs_q[i]), 32'(fs_exp[i]));

      // Reset mid-line with A pending: defaults must come back
      reset = 1'b1;
      tick();
      check("mid_rst_xy", 32'({x, y}), 0);
      check("mid_rst_ready", 32'(cfg_ready), 1);
      check("mid_rst_outputs", 32'({de, hsync, vsync, line_start, frame_start}), 0);
      reset = 1'b0;
      for (int r = 1; r <= 1056; r++) begin
         tick();
         if (r == 2) check("post_rst_fs", 32'(frame_start), 1);
         if (r == 8) check("post_rst_no_pending", 32'({x, y}), 32'({12'd8, 12'd0}));
         if (r == 801) check("post_rst_de_on", 32'(de), 1);
         if (r == 802) check("post_rst_de_off", 32'(de), 0);
         if (r == 841) check("post_rst_hs_before", 32'(hsync), 0);
         if (r == 842) check("post_rst_hs_start", 32'(hsync), 1);
         if (r == 1055) check("post_rst_x_last", 32'(x), 1055);
         if (r == 1056) check("post_rst_wrap", 32'({x, y}), 32'({12'd0, 12'd1}));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
